// File: rtl/fpu_pkg.sv
// Field widths, the binary32 layout and constants shared by the FPU units.
package fpu_pkg;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int BIAS   = 127;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp32_t;

  localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;

endpackage

// File: rtl/itof_pipe_if.sv
// Operand/result bundle of the int-to-float pipe, including the global stall (en).
interface itof_pipe_if;
  logic        en;
  logic        in_valid;
  logic [31:0] x;
  logic        out_valid;
  logic [31:0] z;

  modport master (output en, in_valid, x, input out_valid, z);
  modport slave  (input en, in_valid, x, output out_valid, z);
endinterface

// File: rtl/lzc32.sv
// Combinational 32-bit leading-zero counter; returns 32 for an all-zero input.
module lzc32 (
  input  logic [31:0] a_i,
  output logic [5:0]  cnt_o
);

  // Each node holds an all-zero flag and the zero count within its span;
  // the upper (more significant) child wins unless it is all zero.
  logic [15:0] z0, c0;
  logic [7:0]  z1;
  logic [1:0]  c1 [8];
  logic [3:0]  z2;
  logic [2:0]  c2 [4];
  logic [1:0]  z3;
  logic [3:0]  c3 [2];
  logic        z4;
  logic [4:0]  c4;

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_l0
      assign z0[gi] = ~|a_i[2*gi +: 2];
      assign c0[gi] = ~a_i[2*gi+1];
    end
    for (genvar gi = 0; gi < 8; gi++) begin : g_l1
      assign z1[gi] = z0[2*gi+1] & z0[2*gi];
      assign c1[gi] = z0[2*gi+1] ? {1'b1, c0[2*gi]} : {1'b0, c0[2*gi+1]};
    end
    for (genvar gi = 0; gi < 4; gi++) begin : g_l2
      assign z2[gi] = z1[2*gi+1] & z1[2*gi];
      assign c2[gi] = z1[2*gi+1] ? {1'b1, c1[2*gi]} : {1'b0, c1[2*gi+1]};
    end
    for (genvar gi = 0; gi < 2; gi++) begin : g_l3
      assign z3[gi] = z2[2*gi+1] & z2[2*gi];
      assign c3[gi] = z2[2*gi+1] ? {1'b1, c2[2*gi]} : {1'b0, c2[2*gi+1]};
    end
  endgenerate

  assign z4    = z3[1] & z3[0];
  assign c4    = z3[1] ? {1'b1, c3[0]} : {1'b0, c3[1]};
  assign cnt_o = z4 ? 6'd32 : {1'b0, c4};

endmodule

// File: rtl/itof_pipe.sv
// Two-stage 32-bit integer to binary32 converter: normalise in stage 1,
// round-to-nearest-even and pack in stage 2. en=0 freezes every register.
module itof_pipe
  import fpu_pkg::*;
#(
  parameter bit SIGNED = 1'b1
) (
  input logic        clk,
  input logic        rst,
  itof_pipe_if.slave bus
);

  // ---------------- stage 1: magnitude and normalisation ----------------
  logic        sign_d, zero_d;
  logic [31:0] mag_d, norm_d;
  logic [5:0]  lz_d;

  assign sign_d = SIGNED & bus.x[31];
  assign mag_d  = sign_d ? (~bus.x + 32'd1) : bus.x;

  lzc32 u_lzc (
    .a_i   (mag_d),
    .cnt_o (lz_d)
  );

  // After normalisation the MSB is set for every nonzero magnitude.
  assign norm_d = mag_d << lz_d;
  assign zero_d = ~norm_d[31];

  logic        s1_valid_q, s1_sign_q, s1_zero_q;
  logic [5:0]  s1_lz_q;
  logic [30:0] s1_norm_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_lz_q    <= '0;
      s1_norm_q  <= '0;
    end else if (bus.en) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sign_q <= sign_d;
        s1_zero_q <= zero_d;
        s1_lz_q   <= lz_d;
        s1_norm_q <= norm_d[30:0];
      end
    end
  end

  // ---------------- stage 2: rounding and packing ----------------
  logic [EXP_W-1:0] exp_d;
  logic             guard_d, sticky_d, inc_d;
  logic [30:0]      sum_d;
  fp32_t            z_d;

  assign exp_d    = EXP_W'(BIAS + 31) - {2'b00, s1_lz_q};
  assign guard_d  = s1_norm_q[7];
  assign sticky_d = |s1_norm_q[6:0];
  assign inc_d    = guard_d & (sticky_d | s1_norm_q[8]);
  // A carry out of the mantissa ripples into the exponent field.
  assign sum_d    = {exp_d, s1_norm_q[30:8]} + 31'(inc_d);

  always_comb begin
    z_d = fp32_t'(FP_POS_ZERO);
    if (!s1_zero_q) begin
      z_d.sign = s1_sign_q;
      z_d.exp  = sum_d[30:23];
      z_d.mant = sum_d[22:0];
    end
  end

  logic        out_valid_q;
  logic [31:0] z_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      z_q         <= FP_POS_ZERO;
    end else if (bus.en) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) z_q <= z_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.z         = z_q;

endmodule

// File: tb/tb_itof_pipe.sv
// Scoreboard bench for itof_pipe: a signed and an unsigned instance side by side.
module tb_itof_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  itof_pipe_if if_s ();
  itof_pipe_if if_u ();

  itof_pipe #(.SIGNED(1'b1)) dut_s (.clk(clk), .rst(rst), .bus(if_s));
  itof_pipe #(.SIGNED(1'b0)) dut_u (.clk(clk), .rst(rst), .bus(if_u));

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] sb_s[$];
  logic [31:0] sb_u[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_s(input logic en, input logic v, input logic [31:0] x);
    if_s.en = en; if_s.in_valid = v; if_s.x = x;
  endtask

  task automatic drive_u(input logic en, input logic v, input logic [31:0] x);
    if_u.en = en; if_u.in_valid = v; if_u.x = x;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_s(1'b1, 1'b0, 32'h0);
    drive_u(1'b1, 1'b0, 32'h0);
    tick(); tick();
    n_checks += 4;
    if (if_s.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid_s got=%b want=0", if_s.out_valid); end
    if (if_s.z !== 32'h0) begin n_fail++; $display("FAIL reset_z_s got=%h want=00000000", if_s.z); end
    if (if_u.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid_u got=%b want=0", if_u.out_valid); end
    if (if_u.z !== 32'h0) begin n_fail++; $display("FAIL reset_z_u got=%h want=00000000", if_u.z); end
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic [31:0] xs [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h2, 32'h7FFF_FFFF};
    logic [31:0] es [5] = '{32'h0, 32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 32'h4F00_0000};
    logic [31:0] e;
    for (int k = 0; k < 7; k++) begin
      if (k < 5) begin drive_s(1'b1, 1'b1, xs[k]); sb_s.push_back(es[k]); end
      else drive_s(1'b1, 1'b0, 32'h0);
      tick();
      n_checks++;
      if (if_s.out_valid !== (k >= 1 && k <= 5)) begin
        n_fail++; $display("FAIL basic_valid cycle=%0d got=%b want=%b", k, if_s.out_valid, (k >= 1 && k <= 5));
      end
      if (if_s.out_valid === 1'b1 && sb_s.size() > 0) begin
        e = sb_s.pop_front();
        n_checks++;
        if (if_s.z !== e) begin n_fail++; $display("FAIL basic_z cycle=%0d got=%h want=%h", k, if_s.z, e); end
        else $display("basic ok z=%h", if_s.z);
      end
    end
    n_checks++;
    if (sb_s.size() != 0) begin n_fail++; $display("FAIL basic_drain left=%0d want=0", sb_s.size()); sb_s.delete(); end
  endtask

  task automatic test_rounding();
    logic [31:0] xs [6] = '{32'd16777217, 32'd16777219, 32'd16777221, 32'hFEFF_FFFD, 32'h8000_0000, 32'h00FF_FFFF};
    logic [31:0] es [6] = '{32'h4B80_0000, 32'h4B80_0002, 32'h4B80_0002, 32'hCB80_0002, 32'hCF00_0000, 32'h4B7F_FFFF};
    logic [31:0] e;
    for (int k = 0; k < 8; k++) begin
      if (k < 6) begin drive_s(1'b1, 1'b1, xs[k]); sb_s.push_back(es[k]); end
      else drive_s(1'b1, 1'b0, 32'h0);
      tick();
      n_checks++;
      if (if_s.out_valid !== (k >= 1 && k <= 6)) begin
        n_fail++; $display("FAIL round_valid cycle=%0d got=%b want=%b", k, if_s.out_valid, (k >= 1 && k <= 6));
      end
      if (if_s.out_valid === 1'b1 && sb_s.size() > 0) begin
        e = sb_s.pop_front();
        n_checks++;
        if (if_s.z !== e) begin n_fail++; $display("FAIL round_z cycle=%0d got=%h want=%h", k, if_s.z, e); end
        else $display("rounding ok z=%h", if_s.z);
      end
    end
    n_checks++;
    if (sb_s.size() != 0) begin n_fail++; $display("FAIL round_drain left=%0d want=0", sb_s.size()); sb_s.delete(); end
  endtask

  task automatic test_unsigned();
    logic [31:0] xs [2] = '{32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] es [2] = '{32'h4F80_0000, 32'h4F00_0000};
    logic [31:0] e;
    for (int k = 0; k < 4; k++) begin
      if (k < 2) begin drive_u(1'b1, 1'b1, xs[k]); sb_u.push_back(es[k]); end
      else drive_u(1'b1, 1'b0, 32'h0);
      tick();
      n_checks++;
      if (if_u.out_valid !== (k >= 1 && k <= 2)) begin
        n_fail++; $display("FAIL uns_valid cycle=%0d got=%b want=%b", k, if_u.out_valid, (k >= 1 && k <= 2));
      end
      if (if_u.out_valid === 1'b1 && sb_u.size() > 0) begin
        e = sb_u.pop_front();
        n_checks++;
        if (if_u.z !== e) begin n_fail++; $display("FAIL uns_z cycle=%0d got=%h want=%h", k, if_u.z, e); end
        else $display("unsigned ok z=%h", if_u.z);
      end
    end
    n_checks++;
    if (sb_u.size() != 0) begin n_fail++; $display("FAIL uns_drain left=%0d want=0", sb_u.size()); sb_u.delete(); end
  endtask

  task automatic test_stall();
    logic [31:0] e;
    drive_s(1'b1, 1'b1, 32'd1); sb_s.push_back(32'h3F80_0000);
    tick();
    // Stalled: inputs ignored, output holds the last rounding-test result.
    for (int k = 0; k < 3; k++) begin
      drive_s(1'b0, 1'b1, 32'd7);
      tick();
      n_checks += 2;
      if (if_s.out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_valid cycle=%0d got=%b want=0", k, if_s.out_valid); end
      if (if_s.z !== 32'h4B7F_FFFF) begin n_fail++; $display("FAIL stall_z cycle=%0d got=%h want=4b7fffff", k, if_s.z); end
    end
    drive_s(1'b1, 1'b1, 32'd2); sb_s.push_back(32'h4000_0000);
    tick();
    e = sb_s.pop_front();
    n_checks += 2;
    if (if_s.out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_first_valid got=%b want=1", if_s.out_valid); end
    if (if_s.z !== e) begin n_fail++; $display("FAIL stall_first_z got=%h want=%h", if_s.z, e); end
    for (int k = 0; k < 2; k++) begin
      drive_s(1'b0, 1'b1, 32'd9);
      tick();
      n_checks += 2;
      if (if_s.out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold_valid cycle=%0d got=%b want=1", k, if_s.out_valid); end
      if (if_s.z !== 32'h3F80_0000) begin n_fail++; $display("FAIL stall_hold_z cycle=%0d got=%h want=3f800000", k, if_s.z); end
    end
    drive_s(1'b1, 1'b0, 32'h0);
    tick();
    e = sb_s.pop_front();
    n_checks += 2;
    if (if_s.out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_second_valid got=%b want=1", if_s.out_valid); end
    if (if_s.z !== e) begin n_fail++; $display("FAIL stall_second_z got=%h want=%h", if_s.z, e); end
    tick();
    n_checks += 2;
    if (if_s.out_valid !== 1'b0) begin n_fail++; $display("FAIL bubble_valid got=%b want=0", if_s.out_valid); end
    if (if_s.z !== 32'h4000_0000) begin n_fail++; $display("FAIL bubble_z got=%h want=40000000", if_s.z); end
    $display("test_stall done");
  endtask

  task automatic test_reset_midflight();
    drive_s(1'b1, 1'b1, 32'd5);
    tick();
    rst = 1'b1;
    drive_s(1'b1, 1'b0, 32'h0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks += 2;
      if (if_s.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid cycle=%0d got=%b want=0", k, if_s.out_valid); end
      if (if_s.z !== 32'h0) begin n_fail++; $display("FAIL midrst_z cycle=%0d got=%h want=00000000", k, if_s.z); end
      tick();
    end
    $display("test_reset_midflight done");
  endtask

  initial begin
    rst = 1'b1;
    drive_s(1'b1, 1'b0, 32'h0);
    drive_u(1'b1, 1'b0, 32'h0);
    test_reset();
    test_basic();
    test_rounding();
    test_unsigned();
    test_stall();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
